seg_scan_reader: RTL and testbench

Recovers BCD digits from a multiplexed, scanned 7-segment display bus: segment lines a–g plus a one-hot digit-select. It is the receive end of the BCD-to-segment display path and sits between external display pins (or a display driver under test) and logic that needs the displayed value back as BCD. It synchronises the inputs, waits for each scan slot to settle, decodes the segment pattern, and stores one BCD nibble per digit. It signals when every digit has been captured once.

---
 rtl/seg_scan_reader.sv | 94 +++++++++
 tb/tb_seg_scan_reader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_reader.sv
// Recovers BCD digits from a scanned 7-segment bus: sync, settle, decode, store per digit.
// Capture lands 3+STABLE_CYCLES edges after input change; frame_done one edge later; no backpressure.
module seg_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  err
);

  localparam int SW = DIGITS + 7;
  localparam logic [7:0] SC    = 8'(STABLE_CYCLES);
  localparam logic [7:0] SC_M1 = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]     s1, s2, s3;
  logic [7:0]        cnt;
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] sel;
  logic [6:0]        pat;
  logic              stable, onehot, cap, known;
  logic [3:0]        dec;

  assign {sel, pat} = s2;
  assign stable     = (s2 == s3);
  assign onehot     = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  // Fires only on the edge the counter reaches its last step, never while saturated.
  assign cap        = stable && (cnt == SC_M1) && onehot;

  always_comb begin
    known = 1'b1;
    dec   = 4'h0;
    case (pat)
      7'b0111111: dec = 4'd0;
      7'b0000110: dec = 4'd1;
      7'b1011011: dec = 4'd2;
      7'b1001111: dec = 4'd3;
      7'b1100110: dec = 4'd4;
      7'b1101101: dec = 4'd5;
      7'b1111101: dec = 4'd6;
      7'b0000111: dec = 4'd7;
      7'b1111111: dec = 4'd8;
      7'b1101111: dec = 4'd9;
      default:    known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      cnt         <= '0;
      seen        <= '0;
      bcd         <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      s1 <= {dig_sel, seg};
      s2 <= s1;
      s3 <= s2;

      if (!stable)
        cnt <= '0;
      else if (cnt < SC)
        cnt <= cnt + 8'd1;

      err        <= cap && !known;
      frame_done <= &seen;

      if (cap) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel[i]) begin
            bcd[4*i +: 4]  <= known ? dec : 4'hF;
            digit_valid[i] <= known;
          end
        end
      end

      // A capture landing on the clearing edge opens the next frame.
      if (&seen)
        seen <= cap ? sel : '0;
      else if (cap)
        seen <= seen | sel;
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: stimulus pushes expected output events, a monitor pops and compares.
module tb_seg_scan_reader;

  localparam int D = 4;
  localparam int S = 4;

  localparam logic [6:0] P0 = 7'b0111111, P1 = 7'b0000110, P2 = 7'b1011011,
                         P3 = 7'b1001111, P4 = 7'b1100110, P5 = 7'b1101101,
                         P6 = 7'b1111101, P7 = 7'b0000111, P8 = 7'b1111111,
                         P9 = 7'b1101111, PBAD = 7'b1110110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg = P2;
  logic [D-1:0]  dig_sel = 4'b0001;
  logic [4*D-1:0] bcd;
  logic [D-1:0]  digit_valid;
  logic          frame_done, err;

  seg_scan_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
    .bcd(bcd), .digit_valid(digit_valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] bcd;
    logic [3:0]  dv;
    logic        err;
    logic        fd;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [15:0] b, input logic [3:0] v,
                      input logic e, input logic f);
    ev_t x;
    x.cyc = c; x.bcd = b; x.dv = v; x.err = e; x.fd = f;
    q.push_back(x);
  endtask

  // Drive one scan slot; when has_exp, the capture is expected 3+S edges after the drive point.
  task automatic slot(input logic [3:0] sel, input logic [6:0] s, input int len,
                      input logic has_exp, input logic [15:0] b, input logic [3:0] v,
                      input logic e, input logic fd_next);
    if (has_exp) begin
      push(cyc + 3 + S, b, v, e, 1'b0);
      if (fd_next) push(cyc + 4 + S, b, v, 1'b0, 1'b1);
    end
    dig_sel = sel;
    seg     = s;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int len);
    slot(4'b0000, 7'b0000000, len, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_dv", 32'(digit_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
  endtask

  // Monitor: any pulse or change of the level outputs is an event to be matched in order.
  logic        rst_d = 1'b1;
  logic [15:0] pbcd;
  logic [3:0]  pdv;
  always @(negedge clk) begin
    if (!rst && !rst_d && (err || frame_done || bcd !== pbcd || digit_valid !== pdv)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: bcd=%h dv=%b err=%b fd=%b at cycle %0d, none expected",
                 bcd, digit_valid, err, frame_done, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk("ev_bcd", 32'(bcd), 32'(e.bcd));
        chk("ev_dv", 32'(digit_valid), 32'(e.dv));
        chk("ev_err", 32'(err), 32'(e.err));
        chk("ev_fd", 32'(frame_done), 32'(e.fd));
      end
    end
    rst_d = rst;
    pbcd  = bcd;
    pdv   = digit_valid;
  end

  initial begin
    // Reset with a valid digit already on the bus, then hold it: single capture of '2' on digit 0.
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();
    push(cyc + 3 + S, 16'h0002, 4'b0001, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    blank(2);

    // Full frame 1,2,3,4 on digits 0..3; digit 0 already seen, so its capture is a recapture.
    slot(4'b0001, P1, 10, 1'b1, 16'h0001, 4'b0001, 1'b0, 1'b0); blank(2);
    slot(4'b0010, P2, 10, 1'b1, 16'h0021, 4'b0011, 1'b0, 1'b0); blank(2);
    slot(4'b0100, P3, 10, 1'b1, 16'h0321, 4'b0111, 1'b0, 1'b0); blank(2);
    slot(4'b1000, P4, 10, 1'b1, 16'h4321, 4'b1111, 1'b0, 1'b1); blank(2);

    // Unrecognised pattern on digit 2, held long: one err pulse only.
    slot(4'b0100, PBAD, 20, 1'b1, 16'h4F21, 4'b1011, 1'b1, 1'b0); blank(2);

    // 5-cycle slot with a one-cycle glitch in its third cycle: nothing captured.
    slot(4'b0010, P7, 2, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    slot(4'b0010, P8, 1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    slot(4'b0010, P7, 2, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    blank(4);

    // Multi-hot select held for 20 cycles: nothing captured, no err.
    slot(4'b0011, P9, 20, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0); blank(2);

    // Partial frame, reset, then a full frame: exactly one frame_done after the final digit 3.
    slot(4'b0001, P5, 10, 1'b1, 16'h4F25, 4'b1011, 1'b0, 1'b0); blank(2);
    slot(4'b0010, P6, 10, 1'b1, 16'h4F65, 4'b1011, 1'b0, 1'b0); blank(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();
    blank(2);
    slot(4'b0001, P7, 10, 1'b1, 16'h0007, 4'b0001, 1'b0, 1'b0); blank(2);
    slot(4'b0010, P8, 10, 1'b1, 16'h0087, 4'b0011, 1'b0, 1'b0); blank(2);
    slot(4'b0100, P9, 10, 1'b1, 16'h0987, 4'b0111, 1'b0, 1'b0); blank(2);
    slot(4'b1000, P0, 10, 1'b1, 16'h0987, 4'b1111, 1'b0, 1'b1); blank(10);

    chk("pending_events", 32'(q.size()), 32'h0);
    chk("final_bcd", 32'(bcd), 32'h0987);
    chk("final_dv", 32'(digit_valid), 32'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
